// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives synchronous-read BIOS/IMEM addresses,
// steers the returned word downstream and parks in a fault state on an illegal target.
module fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h4000_0000,
    parameter int          BIOS_AWIDTH = 12,
    parameter int          IMEM_AWIDTH = 14,
    parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stall,
    input  logic                   redirect_valid,
    input  logic [31:0]            redirect_pc,
    output logic [BIOS_AWIDTH-1:0] bios_addr,
    input  logic [31:0]            bios_dout,
    output logic [IMEM_AWIDTH-1:0] imem_addr,
    input  logic [31:0]            imem_dout,
    output logic [31:0]            instruction_o,
    output logic [31:0]            pc_o,
    output logic [31:0]            pc_plus4_o,
    output logic                   valid_o,
    output logic                   fault_o,
    output logic [31:0]            fault_pc_o,
    output logic [31:0]            fetch_count_o
);

    typedef enum logic {RUN, FAULT} state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] fault_pc_reg, fault_pc_next;
    logic [31:0] fetch_count_reg;
    logic        src_reg;
    logic        legal;
    logic        valid;

    // Next PC drives the memories directly, so a stalled cycle re-reads the same word.
    always_comb begin
        if (rst)
            pc_next = RESET_PC;
        else if (state_reg == FAULT)
            pc_next = pc_reg;
        else if (redirect_valid)
            pc_next = redirect_pc;
        else if (stall)
            pc_next = pc_reg;
        else
            pc_next = pc_reg + 32'd4;
    end

    assign legal = (pc_next[1:0] == 2'b00) &&
                   ((pc_next[31:28] == 4'h4) || (pc_next[31:28] == 4'h1));

    always_comb begin
        state_next    = state_reg;
        fault_pc_next = fault_pc_reg;
        valid         = 1'b0;
        case (state_reg)
            RUN: begin
                valid = !redirect_valid;
                if (!legal) begin
                    state_next    = FAULT;
                    fault_pc_next = pc_next;
                end
            end
            FAULT: begin
                valid = 1'b0;
            end
            default: begin
                state_next = FAULT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= RUN;
            pc_reg          <= RESET_PC;
            src_reg         <= RESET_PC[30];
            fault_pc_reg    <= 32'd0;
            fetch_count_reg <= 32'd0;
        end else begin
            state_reg    <= state_next;
            fault_pc_reg <= fault_pc_next;
            src_reg      <= pc_next[30];
            // An illegal target is recorded but never becomes the architectural PC.
            if (state_reg == RUN && legal)
                pc_reg <= pc_next;
            if (valid && !stall)
                fetch_count_reg <= fetch_count_reg + 32'd1;
        end
    end

    assign bios_addr     = pc_next[BIOS_AWIDTH+1:2];
    assign imem_addr     = pc_next[IMEM_AWIDTH+1:2];
    assign instruction_o = valid ? (src_reg ? bios_dout : imem_dout) : NOP_INSTR;
    assign pc_o          = pc_reg;
    assign pc_plus4_o    = pc_reg + 32'd4;
    assign valid_o       = valid;
    assign fault_o       = (state_reg == FAULT);
    assign fault_pc_o    = fault_pc_reg;
    assign fetch_count_o = fetch_count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle expectations are queued by the stimulus
// and compared by an independent negedge monitor against synchronous memory models.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [11:0] bios_addr;
    logic [31:0] bios_dout;
    logic [13:0] imem_addr;
    logic [31:0] imem_dout;
    logic [31:0] instruction_o;
    logic [31:0] pc_o;
    logic [31:0] pc_plus4_o;
    logic        valid_o;
    logic        fault_o;
    logic [31:0] fault_pc_o;
    logic [31:0] fetch_count_o;

    fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .bios_addr      (bios_addr),
        .bios_dout      (bios_dout),
        .imem_addr      (imem_addr),
        .imem_dout      (imem_dout),
        .instruction_o  (instruction_o),
        .pc_o           (pc_o),
        .pc_plus4_o     (pc_plus4_o),
        .valid_o        (valid_o),
        .fault_o        (fault_o),
        .fault_pc_o     (fault_pc_o),
        .fetch_count_o  (fetch_count_o)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories whose contents encode their own word address.
    always @(posedge clk) begin
        bios_dout <= 32'hB000_0000 | {20'd0, bios_addr};
        imem_dout <= 32'hA000_0000 | {18'd0, imem_addr};
    end

    function automatic logic [31:0] bw(input int i);
        return 32'hB000_0000 | i;
    endfunction

    function automatic logic [31:0] iw(input int i);
        return 32'hA000_0000 | i;
    endfunction

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        fault;
        logic [31:0] fault_pc;
        logic [31:0] count;
        int          ba;
        int          ia;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   failed = 0;
    int   passed = 0;

    task automatic chk(input string tag, input string field, input logic [31:0] act,
                       input logic [31:0] req);
        total++;
        if (act !== req) begin
            failed++;
            $display("FAIL %s.%s: got %h expected %h", tag, field, act, req);
        end else begin
            passed++;
        end
    endtask

    // Monitor: the DUT presents a fresh output set every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            $display("cycle %s: pc=%h instr=%h valid=%0b fault=%0b fpc=%h cnt=%0d",
                     e.name, pc_o, instruction_o, valid_o, fault_o, fault_pc_o, fetch_count_o);
            chk(e.name, "pc_o", pc_o, e.pc);
            chk(e.name, "pc_plus4_o", pc_plus4_o, e.pc + 32'd4);
            chk(e.name, "instruction_o", instruction_o, e.instr);
            chk(e.name, "valid_o", {31'd0, valid_o}, {31'd0, e.valid});
            chk(e.name, "fault_o", {31'd0, fault_o}, {31'd0, e.fault});
            chk(e.name, "fault_pc_o", fault_pc_o, e.fault_pc);
            chk(e.name, "fetch_count_o", fetch_count_o, e.count);
            if (e.ba >= 0)
                chk(e.name, "bios_addr", {20'd0, bios_addr}, e.ba);
            if (e.ia >= 0)
                chk(e.name, "imem_addr", {18'd0, imem_addr}, e.ia);
        end
    end

    // Drive one cycle of inputs, queue what that cycle must show, then advance.
    task automatic cyc(input string name, input logic r, input logic s, input logic rv,
                       input logic [31:0] rp, input logic [31:0] pc, input logic [31:0] instr,
                       input logic v, input logic f, input logic [31:0] fpc,
                       input logic [31:0] cnt, input int ba, input int ia);
        exp_t e;
        rst            = r;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rp;
        e.name = name; e.pc = pc; e.instr = instr; e.valid = v; e.fault = f;
        e.fault_pc = fpc; e.count = cnt; e.ba = ba; e.ia = ia;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        @(posedge clk);
        #1;
        //   name       rst st rv redirect_pc     pc_o            instr       v  f  fault_pc       cnt  ba     ia
        cyc("rst_hold",  1, 0, 0, 32'h0,         32'h4000_0000, bw(0),      1, 0, 32'h0,         0,   0,     -1);
        cyc("boot0",     0, 0, 0, 32'h0,         32'h4000_0000, bw(0),      1, 0, 32'h0,         0,   1,     -1);
        cyc("boot1",     0, 0, 0, 32'h0,         32'h4000_0004, bw(1),      1, 0, 32'h0,         1,   2,     -1);
        cyc("stall0",    0, 1, 0, 32'h0,         32'h4000_0008, bw(2),      1, 0, 32'h0,         2,   2,     -1);
        cyc("stall1",    0, 1, 0, 32'h0,         32'h4000_0008, bw(2),      1, 0, 32'h0,         2,   2,     -1);
        cyc("stall2",    0, 1, 0, 32'h0,         32'h4000_0008, bw(2),      1, 0, 32'h0,         2,   2,     -1);
        cyc("unstall",   0, 0, 0, 32'h0,         32'h4000_0008, bw(2),      1, 0, 32'h0,         2,   3,     -1);
        cyc("redir",     0, 0, 1, 32'h1000_0040, 32'h4000_000C, NOP,        0, 0, 32'h0,         3,   -1,    'h10);
        cyc("imem0",     0, 0, 0, 32'h0,         32'h1000_0040, iw('h10),   1, 0, 32'h0,         3,   -1,    'h11);
        cyc("st_redir",  0, 1, 1, 32'h1000_0100, 32'h1000_0044, NOP,        0, 0, 32'h0,         4,   -1,    'h40);
        cyc("imem1",     0, 0, 0, 32'h0,         32'h1000_0100, iw('h40),   1, 0, 32'h0,         4,   -1,    'h41);
        cyc("misalign",  0, 0, 1, 32'h1000_0042, 32'h1000_0104, NOP,        0, 0, 32'h0,         5,   -1,    'h10);
        cyc("fault0",    0, 0, 0, 32'h0,         32'h1000_0104, NOP,        0, 1, 32'h1000_0042, 5,   -1,    'h41);
        cyc("fault_rd",  0, 0, 1, 32'h1000_0200, 32'h1000_0104, NOP,        0, 1, 32'h1000_0042, 5,   -1,    'h41);
        cyc("fault_rst", 1, 0, 0, 32'h0,         32'h1000_0104, NOP,        0, 1, 32'h1000_0042, 5,   0,     0);
        cyc("reboot",    0, 0, 0, 32'h0,         32'h4000_0000, bw(0),      1, 0, 32'h0,         0,   1,     -1);
        cyc("bad_rgn",   0, 0, 1, 32'h2000_0000, 32'h4000_0004, NOP,        0, 0, 32'h0,         1,   0,     0);
        cyc("fault1",    0, 0, 0, 32'h0,         32'h4000_0004, NOP,        0, 1, 32'h2000_0000, 1,   1,     -1);
        cyc("fault_rs2", 1, 0, 0, 32'h0,         32'h4000_0004, NOP,        0, 1, 32'h2000_0000, 1,   0,     -1);
        cyc("to_edge",   0, 0, 1, 32'h4FFF_FFFC, 32'h4000_0000, NOP,        0, 0, 32'h0,         0,   'hFFF, -1);
        cyc("edge",      0, 0, 0, 32'h0,         32'h4FFF_FFFC, bw('hFFF),  1, 0, 32'h0,         0,   0,     -1);
        cyc("walkoff",   0, 0, 0, 32'h0,         32'h4FFF_FFFC, NOP,        0, 1, 32'h5000_0000, 1,   'hFFF, -1);
        cyc("mid_rst",   1, 0, 0, 32'h0,         32'h4FFF_FFFC, NOP,        0, 1, 32'h5000_0000, 1,   0,     -1);
        cyc("run_again", 0, 0, 0, 32'h0,         32'h4000_0000, bw(0),      1, 0, 32'h0,         0,   1,     -1);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++)
            @(posedge clk);
        if (exp_q.size() > 0) begin
            total++;
            failed++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
